// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared types and defaults for the relay memory responder
package relay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } mem_state_t;

    localparam int RELAY_ADDR_W = 16;
    localparam int RELAY_DATA_W = 8;
    localparam int SETTLE_CNT_W = 4;

    function automatic logic even_parity(input logic [RELAY_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/relay_settle_timer.sv
// rtl/relay_settle_timer.sv - loadable down-counter with zero flag for relay settle timing
module relay_settle_timer
    import relay_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    dec,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    output logic                    zero
);

    logic [SETTLE_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_addr_responder.sv
// rtl/mem_addr_responder.sv - relay-timed memory responder; MEM_PARITY_EN adds per-word even parity
module mem_addr_responder
    import relay_pkg::*;
#(
    parameter int ADDR_W        = RELAY_ADDR_W,
    parameter int DATA_W        = RELAY_DATA_W,
    parameter int SETTLE_CYCLES = 3
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              addr_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_drive,
    output logic              busy,
    output logic              done,
    output logic              strobe_err,
    output logic              led_rd,
    output logic              led_wr,
    output logic              parity_err
);

    localparam int DEPTH = 1 << ADDR_W;

    mem_state_t        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_write;
    logic              armed;
    logic              accept;
    logic              active;
    logic              mem_we;
    logic              tmr_zero;

    assign led_rd = mem_read;
    assign led_wr = mem_write;

    // armed blocks a still-held strobe from retriggering until both strobes were seen low
    assign accept = (state == ST_IDLE) && addr_valid && (mem_read ^ mem_write) && armed;
    assign active = op_write ? mem_write : mem_read;
    assign mem_we = (state == ST_ACCESS) && op_write && !reset;

    relay_settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .dec      (state == ST_SETTLE),
        .load_val (SETTLE_CNT_W'(SETTLE_CYCLES - 1)),
        .zero     (tmr_zero)
    );

    // Storage has no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[addr_q] <= even_parity(wdata_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else if ((state == ST_ACCESS) && !op_write) begin
            par_err_q <= (even_parity(mem[addr_q]) != par_mem[addr_q]);
        end else if ((state == ST_HOLD) && !active) begin
            par_err_q <= 1'b0;
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write   <= 1'b0;
            armed      <= 1'b0;
            data_out   <= '0;
            data_drive <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            strobe_err <= 1'b0;
        end else begin
            done       <= 1'b0;
            strobe_err <= 1'b0;
            if (!mem_read && !mem_write) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (addr_valid && mem_read && mem_write) begin
                        strobe_err <= 1'b1;
                    end else if (accept) begin
                        addr_q   <= address;
                        wdata_q  <= data_in;
                        op_write <= mem_write;
                        armed    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!active) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tmr_zero) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!op_write) begin
                        data_out   <= mem[addr_q];
                        data_drive <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!active) begin
                        data_drive <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_responder.sv
// tb/tb_mem_addr_responder.sv - scoreboard bench for mem_addr_responder
module tb_mem_addr_responder;

    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        addr_valid;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_drive;
    logic        busy;
    logic        done;
    logic        strobe_err;
    logic        led_rd;
    logic        led_wr;
    logic        parity_err;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic drive_q = 1'b0;

    mem_addr_responder #(.ADDR_W(16), .DATA_W(8), .SETTLE_CYCLES(SC)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .addr_valid (addr_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_drive (data_drive),
        .busy       (busy),
        .done       (done),
        .strobe_err (strobe_err),
        .led_rd     (led_rd),
        .led_wr     (led_wr),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (data_drive && !drive_q) begin
            if (sb.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("read_data", 32'(data_out), 32'(e.data));
                check("read_latency", 32'(cyc - e.cyc), 32'(SC + 1));
                check("parity_err", 32'(parity_err), 32'(e.perr));
            end
        end
        drive_q = data_drive;
    end

    task automatic idle_bus();
        addr_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
    endtask

    task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input logic [15:0] a2,
                          input logic [7:0] d2, input logic perr);
        exp_t e;
        int   d0;
        @(posedge clk); #1;
        d0         = done_cnt;
        address    = a;
        data_in    = d;
        addr_valid = 1'b1;
        mem_read   = !wr;
        mem_write  = wr;
        if (!wr) begin
            e.data = exp;
            e.cyc  = cyc + 1;
            e.perr = perr;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        address = a2;
        data_in = d2;
        repeat (SC + 2) @(posedge clk);
        #1;
        check(wr ? "hold_busy_wr" : "hold_busy_rd", 32'(busy), 32'd1);
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        access(1'b1, a, d, 8'h00, a, d, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp);
        access(1'b0, a, 8'h00, exp, a, 8'h00, 1'b0);
    endtask

    initial begin
        int d0;
        idle_bus();
        address = '0;
        data_in = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_drive", 32'(data_drive), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobe_err", 32'(strobe_err), 32'd0);
        reset = 1'b0;

        mem_read = 1'b1;
        #1;
        check("led_rd", 32'(led_rd), 32'd1);
        check("led_wr", 32'(led_wr), 32'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);

        wr(16'h1234, 8'hA5);
        rd(16'h1234, 8'hA5);

        wr(16'h0000, 8'h11);
        wr(16'hFFFF, 8'hEE);
        rd(16'h0000, 8'h11);
        rd(16'hFFFF, 8'hEE);

        wr(16'h0010, 8'h5A);
        wr(16'h0020, 8'hC3);
        access(1'b0, 16'h0010, 8'h00, 8'h5A, 16'h0020, 8'h00, 1'b0);
        access(1'b1, 16'h0030, 8'h21, 8'h00, 16'h0031, 8'h99, 1'b0);
        rd(16'h0030, 8'h21);

        // write abort: strobe drops while settling
        wr(16'h0001, 8'h44);
        @(posedge clk); #1;
        d0         = done_cnt;
        address    = 16'h0001;
        data_in    = 8'h3C;
        addr_valid = 1'b1;
        mem_write  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle_bus();
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rd(16'h0001, 8'h44);

        // both strobes together
        @(posedge clk); #1;
        addr_valid = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        @(posedge clk); #1;
        check("strobe_err_pulse", 32'(strobe_err), 32'd1);
        check("strobe_err_busy", 32'(busy), 32'd0);
        idle_bus();
        @(posedge clk); #1;
        check("strobe_err_clear", 32'(strobe_err), 32'd0);
        check("strobe_err_busy2", 32'(busy), 32'd0);

        // reset during ACCESS of a write
        wr(16'h0040, 8'h77);
        rd(16'h0040, 8'h77);
        @(posedge clk); #1;
        d0         = done_cnt;
        address    = 16'h0040;
        data_in    = 8'h99;
        addr_valid = 1'b1;
        mem_write  = 1'b1;
        repeat (SC + 1) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstacc_data_out", 32'(data_out), 32'd0);
        check("rstacc_drive", 32'(data_drive), 32'd0);
        check("rstacc_busy", 32'(busy), 32'd0);
        check("rstacc_done", 32'(done), 32'd0);
        reset = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        check("rstacc_no_done", 32'(done_cnt - d0), 32'd0);
        rd(16'h0040, 8'h77);

`ifdef MEM_PARITY_EN
        wr(16'h0100, 8'h5A);
        dut.par_mem[16'h0100] = ~dut.par_mem[16'h0100];
        access(1'b0, 16'h0100, 8'h00, 8'h5A, 16'h0100, 8'h00, 1'b1);
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
